// File: rtl/tmr_voter_reg_pkg.sv
// Shared types and defaults for the triple-modular-redundancy voter.
// The run counter is sized for the largest legal fault threshold (255).
package tmr_pkg;
    localparam int NUM_LANES        = 3;
    localparam int DEF_WIDTH        = 4;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_FAULT_THRESH = 3;
    localparam int RUN_W            = 8;

    typedef enum logic [1:0] {
        LANE_OK,
        LANE_SUSPECT,
        LANE_FAULTY
    } lane_state_e;
endpackage

// File: rtl/tmr_voter_reg_if.sv
// Vote request/response bundle between a lane source and the voter.
interface tmr_voter_reg_if #(
    parameter int WIDTH = tmr_pkg::DEF_WIDTH,
    parameter int CNT_W = tmr_pkg::DEF_CNT_W
);
    logic             in_valid;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic [WIDTH-1:0] data_3;
    logic             clr_err;
    logic             out_valid;
    logic [WIDTH-1:0] tmr_out;
    logic [2:0]       lane_err;
    logic             multi_err;
    logic [CNT_W-1:0] err_cnt_1;
    logic [CNT_W-1:0] err_cnt_2;
    logic [CNT_W-1:0] err_cnt_3;
    logic [2:0]       lane_faulty;

    modport master (
        output in_valid, data_1, data_2, data_3, clr_err,
        input  out_valid, tmr_out, lane_err, multi_err,
               err_cnt_1, err_cnt_2, err_cnt_3, lane_faulty
    );
    modport slave (
        input  in_valid, data_1, data_2, data_3, clr_err,
        output out_valid, tmr_out, lane_err, multi_err,
               err_cnt_1, err_cnt_2, err_cnt_3, lane_faulty
    );
endinterface

// File: rtl/tmr_lane_monitor.sv
// Per-lane health tracker: saturating error total, consecutive-error run
// counter and OK/SUSPECT/FAULTY state machine. Fault state is sticky.
module tmr_lane_monitor
    import tmr_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int FAULT_THRESH = DEF_FAULT_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vote,
    input  logic             err,
    input  logic             clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic             faulty
);
    localparam logic [RUN_W-1:0] THRESH = RUN_W'(FAULT_THRESH);

    lane_state_e      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LANE_OK;
            run_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        // Clear wins over a same-cycle error, which is simply dropped.
        if (clr) begin
            state_d = LANE_OK;
            run_d   = '0;
            cnt_d   = '0;
        end else if (vote) begin
            if (err && cnt_q != '1) cnt_d = cnt_q + 1'b1;
            case (state_q)
                LANE_OK: begin
                    if (err) begin
                        run_d   = RUN_W'(1);
                        state_d = (THRESH == RUN_W'(1)) ? LANE_FAULTY : LANE_SUSPECT;
                    end
                end
                LANE_SUSPECT: begin
                    if (err) begin
                        run_d = run_q + 1'b1;
                        if (run_q + 1'b1 == THRESH) state_d = LANE_FAULTY;
                    end else begin
                        run_d   = '0;
                        state_d = LANE_OK;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err_cnt = cnt_q;
    assign faulty  = (state_q == LANE_FAULTY);
endmodule

// File: rtl/tmr_voter_reg.sv
// Registered bitwise 2-of-3 majority voter with per-lane error reporting.
// Fault status is report-only; the vote is always plain majority.
module tmr_voter_reg
    import tmr_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int FAULT_THRESH = DEF_FAULT_THRESH
) (
    input logic             clk,
    input logic             rst_n,
    tmr_voter_reg_if.slave  bus
);
    logic [NUM_LANES-1:0][WIDTH-1:0] data;
    logic [WIDTH-1:0]                maj;
    logic [NUM_LANES-1:0]            lane_err_d;
    logic                            multi_d;

    logic [WIDTH-1:0]                tmr_q;
    logic [NUM_LANES-1:0]            lane_err_q;
    logic                            multi_q;
    logic                            vld_pipe;

    logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
    logic [NUM_LANES-1:0]            faulty;

    assign data    = {bus.data_3, bus.data_2, bus.data_1};
    assign maj     = (data[0] & data[1]) | (data[0] & data[2]) | (data[1] & data[2]);
    assign multi_d = (lane_err_d[0] & lane_err_d[1]) | (lane_err_d[0] & lane_err_d[2]) |
                     (lane_err_d[1] & lane_err_d[2]);

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            assign lane_err_d[i] = |(data[i] ^ maj);

            tmr_lane_monitor #(
                .CNT_W       (CNT_W),
                .FAULT_THRESH(FAULT_THRESH)
            ) u_mon (
                .clk    (clk),
                .rst_n  (rst_n),
                .vote   (bus.in_valid),
                .err    (lane_err_d[i]),
                .clr    (bus.clr_err),
                .err_cnt(cnt[i]),
                .faulty (faulty[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= 1'b0;
            tmr_q      <= '0;
            lane_err_q <= '0;
            multi_q    <= 1'b0;
        end else begin
            vld_pipe <= bus.in_valid;
            if (bus.in_valid) begin
                tmr_q      <= maj;
                lane_err_q <= lane_err_d;
                multi_q    <= multi_d;
            end
        end
    end

    assign bus.out_valid   = vld_pipe;
    assign bus.tmr_out     = tmr_q;
    assign bus.lane_err    = lane_err_q;
    assign bus.multi_err   = multi_q;
    assign bus.err_cnt_1   = cnt[0];
    assign bus.err_cnt_2   = cnt[1];
    assign bus.err_cnt_3   = cnt[2];
    assign bus.lane_faulty = faulty;
endmodule

// File: tb/tb_tmr_voter_reg.sv
// Directed and randomized checks of tmr_voter_reg against a behavioural
// model of the voting, counting and fault-run rules.
module tb_tmr_voter_reg;
    localparam int W    = 4;
    localparam int CW   = 2;
    localparam int TH   = 3;
    localparam int CMAX = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tmr_voter_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    tmr_voter_reg #(.WIDTH(W), .CNT_W(CW), .FAULT_THRESH(TH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int vecs = 0;
    int errs = 0;

    logic         e_valid;
    logic [W-1:0] e_out;
    logic [2:0]   e_lerr;
    logic         e_multi;
    int           cnt[3];
    int           run[3];
    bit           flt[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"},   32'(bus.out_valid),   32'(e_valid));
        check({tag, ".tmr_out"},     32'(bus.tmr_out),     32'(e_out));
        check({tag, ".lane_err"},    32'(bus.lane_err),    32'(e_lerr));
        check({tag, ".multi_err"},   32'(bus.multi_err),   32'(e_multi));
        check({tag, ".err_cnt_1"},   32'(bus.err_cnt_1),   32'(cnt[0]));
        check({tag, ".err_cnt_2"},   32'(bus.err_cnt_2),   32'(cnt[1]));
        check({tag, ".err_cnt_3"},   32'(bus.err_cnt_3),   32'(cnt[2]));
        check({tag, ".lane_faulty"}, 32'(bus.lane_faulty), 32'({flt[2], flt[1], flt[0]}));
    endtask

    task automatic model_reset();
        e_valid = 1'b0;
        e_out   = '0;
        e_lerr  = '0;
        e_multi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            run[i] = 0;
            flt[i] = 1'b0;
        end
    endtask

    // Majority by counting ones per bit; a lane is faulty once its run of
    // consecutive erroneous votes reaches TH.
    task automatic model_vote(input logic v, input logic [W-1:0] a, b, c, input logic clr);
        logic [W-1:0] d[3];
        int ones;
        int n;
        d[0] = a; d[1] = b; d[2] = c;
        e_valid = v;
        if (v) begin
            for (int k = 0; k < W; k++) begin
                ones = 0;
                for (int i = 0; i < 3; i++) ones += int'(d[i][k]);
                e_out[k] = (ones >= 2);
            end
            n = 0;
            for (int i = 0; i < 3; i++) begin
                e_lerr[i] = (d[i] != e_out);
                if (e_lerr[i]) n++;
            end
            e_multi = (n >= 2);
            if (!clr) begin
                for (int i = 0; i < 3; i++) begin
                    if (e_lerr[i]) begin
                        if (cnt[i] < CMAX) cnt[i]++;
                        run[i]++;
                        if (run[i] >= TH) flt[i] = 1'b1;
                    end else if (!flt[i]) begin
                        run[i] = 0;
                    end
                end
            end
        end
        if (clr) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] = 0;
                run[i] = 0;
                flt[i] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] a, b, c, input logic clr, input string tag);
        @(negedge clk);
        bus.in_valid = v;
        bus.data_1   = a;
        bus.data_2   = b;
        bus.data_3   = c;
        bus.clr_err  = clr;
        model_vote(v, a, b, c, clr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.clr_err  = 1'b0;
        bus.data_1   = '0;
        bus.data_2   = '0;
        bus.data_3   = '0;
        model_reset();
        #1;
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] base, a, b, c;
        logic v, clr;

        do_reset();

        // Lane 2 disagrees on two clean-majority votes
        step(1'b1, 4'b1111, 4'b1011, 4'b1111, 1'b0, "clean1");
        check("clean1.tmr", 32'(bus.tmr_out), 32'h0000000f);
        check("clean1.lerr", 32'(bus.lane_err), 32'h2);
        step(1'b1, 4'b1011, 4'b1001, 4'b1011, 1'b0, "clean2");
        check("clean2.tmr", 32'(bus.tmr_out), 32'h0000000b);
        check("clean2.cnt2", 32'(bus.err_cnt_2), 32'h2);
        check("clean2.faulty", 32'(bus.lane_faulty), 32'h0);

        do_reset();
        step(1'b1, 4'b1010, 4'b1011, 4'b1111, 1'b0, "split");
        check("split.tmr", 32'(bus.tmr_out), 32'h0000000b);
        check("split.lerr", 32'(bus.lane_err), 32'h5);
        check("split.multi", 32'(bus.multi_err), 32'h1);

        do_reset();
        step(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, "th1");
        step(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, "th2");
        check("th2.faulty", 32'(bus.lane_faulty), 32'h0);
        step(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, "th3");
        check("th3.faulty", 32'(bus.lane_faulty), 32'h4);
        step(1'b1, 4'b0110, 4'b0110, 4'b0110, 1'b0, "sticky");
        check("sticky.faulty", 32'(bus.lane_faulty), 32'h4);

        do_reset();
        step(1'b1, 4'b0000, 4'b0000, 4'b1000, 1'b0, "wwcw1");
        step(1'b1, 4'b0000, 4'b0000, 4'b1000, 1'b0, "wwcw2");
        step(1'b1, 4'b0011, 4'b0011, 4'b0011, 1'b0, "wwcw3");
        step(1'b1, 4'b0000, 4'b0000, 4'b1000, 1'b0, "wwcw4");
        step(1'b0, 4'b1111, 4'b0000, 4'b0101, 1'b0, "idle");
        check("wwcw.faulty", 32'(bus.lane_faulty), 32'h0);

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, "sat");
        check("sat.cnt1", 32'(bus.err_cnt_1), 32'h3);

        do_reset();
        step(1'b1, 4'b0101, 4'b0100, 4'b0101, 1'b0, "pre1");
        step(1'b1, 4'b0101, 4'b0100, 4'b0101, 1'b0, "pre2");
        step(1'b1, 4'b0101, 4'b0100, 4'b0101, 1'b1, "clr");
        check("clr.lerr", 32'(bus.lane_err), 32'h2);
        check("clr.cnt2", 32'(bus.err_cnt_2), 32'h0);
        check("clr.faulty", 32'(bus.lane_faulty), 32'h0);
        check("clr.valid", 32'(bus.out_valid), 32'h1);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            base = W'($urandom);
            a = base ^ (($urandom_range(3) == 0) ? W'($urandom) : W'(0));
            b = base ^ (($urandom_range(3) == 0) ? W'($urandom) : W'(0));
            c = base ^ (($urandom_range(2) == 0) ? W'($urandom) : W'(0));
            v   = ($urandom_range(9) != 0);
            clr = ($urandom_range(29) == 0);
            step(v, a, b, c, clr, "rand");
            if (n == 200) begin
                // Asynchronous reset between edges mid-stream
                #2;
                rst_n        = 1'b0;
                bus.in_valid = 1'b0;
                bus.clr_err  = 1'b0;
                model_reset();
                #1;
                check_all("midrst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/tmr_voter_reg.md
TMR_VOTER_REG -- requirements
Module: tmr_voter_reg

Interface
REQ-001 Parameter WIDTH, default 4, sets the bit width of each voted lane.
REQ-002 Parameter CNT_W, default 8, sets the width of each per-lane error counter.
REQ-003 Parameter FAULT_THRESH, default 3, is the number of consecutive erroneous votes that marks a lane faulty; legal range 1..255.
REQ-004 clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 in_valid, input, 1 bit: data_1/2/3 hold a sample to vote this cycle.
REQ-007 data_1, data_2, data_3, inputs, WIDTH bits each: the three redundant lanes.
REQ-008 clr_err, input, 1 bit: synchronous clear of counters and lane fault states.
REQ-009 out_valid, output, 1 bit: tmr_out and the vote flags are valid this cycle.
REQ-010 tmr_out, output, WIDTH bits: registered bitwise 2-of-3 majority.
REQ-011 lane_err, output, 3 bits: bit i set when lane i+1 differed from tmr_out in any bit in the registered vote.
REQ-012 multi_err, output, 1 bit: two or more lane_err bits are set in the registered vote.
REQ-013 err_cnt_1, err_cnt_2, err_cnt_3, outputs, CNT_W bits each: saturating per-lane error totals.
REQ-014 lane_faulty, output, 3 bits: sticky per-lane fault flags.

Function
REQ-015 On a rising edge with in_valid=1, tmr_out SHALL take (d1&d2)|(d1&d3)|(d2&d3) and lane_err/multi_err SHALL be computed from the same sample. Latency is exactly 1 cycle.
REQ-016 out_valid SHALL equal in_valid delayed by one cycle.
REQ-017 On a cycle with in_valid=0, tmr_out, lane_err and multi_err SHALL hold their previous values, and counters and lane states SHALL not change.
REQ-018 Each valid vote with lane i erroneous SHALL increment err_cnt_i by 1. The counter saturates at 2^CNT_W-1 and never wraps.
REQ-019 Each lane SHALL run an FSM with states LANE_OK, LANE_SUSPECT and LANE_FAULTY, plus a consecutive-error run counter.
REQ-020 LANE_OK -> LANE_SUSPECT on an erroneous vote; the run counter is set to 1.
REQ-021 LANE_SUSPECT -> LANE_OK on a clean valid vote; the run counter is cleared.
REQ-022 In LANE_SUSPECT, each erroneous vote increments the run counter. The lane moves to LANE_FAULTY on the edge at which the run count reaches FAULT_THRESH.
REQ-023 With FAULT_THRESH=1, LANE_OK SHALL go directly to LANE_FAULTY on the first erroneous vote.
REQ-024 LANE_FAULTY is sticky: clean votes do not leave it, and only clr_err or reset exits it.
REQ-025 lane_faulty[i] SHALL be 1 iff lane i is in LANE_FAULTY, registered and visible in the same cycle as the out_valid of the vote that caused the transition.
REQ-026 Voting SHALL remain plain majority regardless of lane_faulty; fault status is report-only.
REQ-027 clr_err=1 SHALL zero all err_cnt, run counters and lane states on that edge.
  - clr_err has priority over any error in the same cycle; that error is discarded.
  - tmr_out, out_valid, lane_err and multi_err for that cycle's vote still update normally.
REQ-028 All three lanes differing from each other in the same bit cannot occur with 3 inputs; multi_err covers disagreement spread across bits (e.g. 1010/1011/1111).

Reset
REQ-029 While rst_n=0, all of the following SHALL be 0 asynchronously:
  - tmr_out, out_valid, lane_err, multi_err, err_cnt_1..3, lane_faulty;
  - all run counters;
  - all lane FSMs, which enter LANE_OK.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight vote; the first valid vote after deassertion produces out_valid one cycle later.
REQ-031 Reset deassertion SHALL be used synchronously to clk only through flop clear; no reset synchroniser is inside this block.

Structure
REQ-032 Package tmr_pkg SHALL hold:
  - the lane_state_e enum (LANE_OK, LANE_SUSPECT, LANE_FAULTY);
  - the default WIDTH, CNT_W and FAULT_THRESH constants;
  - the NUM_LANES=3 constant.
REQ-033 Sub-module tmr_lane_monitor SHALL implement one lane's error counter, run counter and FSM, and is instantiated 3 times; voting and flag registers stay in tmr_voter_reg.

Verification
REQ-034 Clean votes:
  - Stimulus: in_valid=1 with d=1111/1011/1111, then 1011/1001/1011.
  - Response: tmr_out=1111 then 1011; lane_err=010 both cycles; multi_err=0; err_cnt_2=2; lane_faulty=000.
REQ-035 Split disagreement:
  - Stimulus: d=1010/1011/1111.
  - Response: tmr_out=1011, lane_err=101, multi_err=1.
REQ-036 Fault threshold (FAULT_THRESH=3):
  - Stimulus: lane 3 wrong on 3 consecutive valid votes.
  - Response: lane_faulty=100 after the 3rd out_valid.
  - Variant: wrong, wrong, clean, wrong leaves lane_faulty=000.
REQ-037 Saturation (CNT_W=2):
  - Stimulus: 5 errors on lane 1.
  - Response: err_cnt_1=3.
REQ-038 clr_err collision:
  - Stimulus: clr_err=1 in the same cycle as a lane-2 error.
  - Response: next cycle tmr_out is valid, lane_err=010, err_cnt_2=0, lane_faulty=000.
REQ-039 Reset mid-stream:
  - Stimulus: rst_n pulled low between clock edges during a run of valid votes.
  - Response: all outputs read 0 immediately, before the next clock edge.
